// File: rtl/m_store_aligner_pkg.sv
// Shared size encodings, widths and log2 helper for the store aligner slice.
package m_store_aligner_pkg;

  localparam int unsigned ADDR_W = 32;

  // Store access size as presented on st_size.
  typedef enum logic [1:0] {
    SZ_WORD  = 2'b00,
    SZ_BYTE  = 2'b01,
    SZ_HALF  = 2'b10,
    SZ_DWORD = 2'b11
  } st_size_e;

  // Ceiling log2 for elaboration-time sizing of pointers and lane offsets.
  function automatic int unsigned clog2_f(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/store_lane_align.sv
// Combinational lane placement and misalignment detection for one store.
module store_lane_align
  import m_store_aligner_pkg::*;
#(
  parameter int unsigned DW = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [DW-1:0]     data,
  input  logic [1:0]        size,
  output logic [ADDR_W-1:0] line_addr_c,
  output logic [DW-1:0]     lane_data_c,
  output logic [DW/8-1:0]   lane_be_c,
  output logic              misaligned_c
);

  localparam int unsigned NB   = DW / 8;
  localparam int unsigned OFFW = clog2_f(NB);

  logic [OFFW-1:0] off;
  logic [DW-1:0]   data_mask;
  logic [NB-1:0]   be_mask;

  assign off = addr[OFFW-1:0];

  // Right-justified size masks and the natural-alignment rule per size.
  always_comb begin
    data_mask    = '0;
    be_mask      = '0;
    misaligned_c = 1'b0;
    case (size)
      SZ_BYTE: begin
        data_mask = DW'(64'h0000_0000_0000_00FF);
        be_mask   = NB'(8'h01);
      end
      SZ_HALF: begin
        data_mask    = DW'(64'h0000_0000_0000_FFFF);
        be_mask      = NB'(8'h03);
        misaligned_c = addr[0];
      end
      SZ_WORD: begin
        data_mask    = DW'(64'h0000_0000_FFFF_FFFF);
        be_mask      = NB'(8'h0F);
        misaligned_c = |addr[1:0];
      end
      SZ_DWORD: begin
        if (DW == 64) begin
          data_mask    = DW'(64'hFFFF_FFFF_FFFF_FFFF);
          be_mask      = NB'(8'hFF);
          misaligned_c = |addr[2:0];
        end else begin
          misaligned_c = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Masking before the shift keeps every non-enabled lane at zero.
  assign lane_data_c = (data & data_mask) << {off, 3'b000};
  assign lane_be_c   = be_mask << off;
  assign line_addr_c = {addr[ADDR_W-1:OFFW], OFFW'(0)};

endmodule

// File: rtl/m_store_aligner.sv
// Store buffer: aligns stores to memory lanes, merges into the tail, drains FIFO.
module m_store_aligner
  import m_store_aligner_pkg::*;
#(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DW-1:0]     st_data,
  input  logic [1:0]        st_size,
  output logic              st_err,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DW-1:0]     mem_wdata,
  output logic [DW/8-1:0]   mem_be,
  output logic              sb_empty
);

  localparam int unsigned NB = DW / 8;
  localparam int unsigned PW = clog2_f(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [ADDR_W-1:0] line_addr_c;
  logic [DW-1:0]     lane_data_c;
  logic [NB-1:0]     lane_be_c;
  logic              misaligned_c;

  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW-1:0] tail_last_c;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [DW-1:0]     data_q [DEPTH];
  logic [DW-1:0]     data_d [DEPTH];
  logic [NB-1:0]     be_q   [DEPTH];
  logic [NB-1:0]     be_d   [DEPTH];

  logic          full_c;
  logic          push_acc_c;
  logic          merge_c;
  logic          enq_c;
  logic          pop_c;
  logic [DW-1:0] be_bits_c;

  store_lane_align #(.DW(DW)) u_align (
    .addr         (st_addr),
    .data         (st_data),
    .size         (st_size),
    .line_addr_c  (line_addr_c),
    .lane_data_c  (lane_data_c),
    .lane_be_c    (lane_be_c),
    .misaligned_c (misaligned_c)
  );

  // Misaligned stores are always swallowed; aligned ones wait for space.
  assign full_c      = (count_q == CW'(DEPTH));
  assign st_ready    = misaligned_c | ~full_c;
  assign tail_last_c = tail_q - PW'(1);
  assign push_acc_c  = st_valid & ~misaligned_c & ~full_c;
  // With two or more entries the tail is never the head, so merging is safe.
  assign merge_c     = push_acc_c & (count_q >= CW'(2)) &
                       (addr_q[tail_last_c] == line_addr_c);
  assign enq_c       = push_acc_c & ~merge_c;
  assign pop_c       = mem_valid & mem_ready;

  // Expand byte enables to a per-bit mask for merging.
  always_comb begin
    be_bits_c = '0;
    for (int i = 0; i < int'(NB); i++) begin
      be_bits_c[i*8 +: 8] = {8{lane_be_c[i]}};
    end
  end

  // Next-state of pointers, occupancy and entry storage.
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    addr_d  = addr_q;
    data_d  = data_q;
    be_d    = be_q;
    if (merge_c) begin
      data_d[tail_last_c] = (data_q[tail_last_c] & ~be_bits_c) | lane_data_c;
      be_d[tail_last_c]   = be_q[tail_last_c] | lane_be_c;
    end
    if (enq_c) begin
      addr_d[tail_q] = line_addr_c;
      data_d[tail_q] = lane_data_c;
      be_d[tail_q]   = lane_be_c;
      tail_d         = tail_q + PW'(1);
    end
    if (pop_c) begin
      head_d = head_q + PW'(1);
    end
    count_d = count_q + CW'(enq_c) - CW'(pop_c);
  end

  // Entry storage; contents are don't-care while not counted.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      addr_q[i] <= addr_d[i];
      data_q[i] <= data_d[i];
      be_q[i]   <= be_d[i];
    end
  end

  // Control state and registered memory-side view of the next head entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q   <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      st_err    <= 1'b0;
      sb_empty  <= 1'b1;
    end else begin
      count_q   <= count_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      mem_valid <= (count_d != '0);
      sb_empty  <= (count_d == '0);
      st_err    <= st_valid & misaligned_c;
      if (count_d != '0) begin
        mem_addr  <= addr_d[head_d];
        mem_wdata <= data_d[head_d];
        mem_be    <= be_d[head_d];
      end else begin
        mem_addr  <= '0;
        mem_wdata <= '0;
        mem_be    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_m_store_aligner.sv
// Bench for m_store_aligner: queue model plus directed literal vectors.
module tb_m_store_aligner;
  import m_store_aligner_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        st_valid, st_ready, st_err;
  logic [31:0] st_addr, st_data;
  logic [1:0]  st_size;
  logic        mem_valid, mem_ready, sb_empty;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  logic        w_st_valid, w_st_ready, w_st_err;
  logic [31:0] w_st_addr;
  logic [63:0] w_st_data;
  logic [1:0]  w_st_size;
  logic        w_mem_valid, w_mem_ready, w_sb_empty;
  logic [31:0] w_mem_addr;
  logic [63:0] w_mem_wdata;
  logic [7:0]  w_mem_be;

  m_store_aligner #(.DW(32), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data), .st_size(st_size), .st_err(st_err),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .sb_empty(sb_empty)
  );

  m_store_aligner #(.DW(64), .DEPTH(4)) dut64 (
    .clk(clk), .reset(reset), .st_valid(w_st_valid), .st_ready(w_st_ready),
    .st_addr(w_st_addr), .st_data(w_st_data), .st_size(w_st_size), .st_err(w_st_err),
    .mem_valid(w_mem_valid), .mem_ready(w_mem_ready), .mem_addr(w_mem_addr),
    .mem_wdata(w_mem_wdata), .mem_be(w_mem_be), .sb_empty(w_sb_empty)
  );

  int total  = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Model entry: line address, lane data and byte enables.
  typedef struct {
    logic [31:0] a;
    logic [63:0] d;
    logic [7:0]  be;
  } ent_t;

  ent_t q[$];
  bit   err_exp = 1'b0;

  // Arithmetic statement of the lane rules.
  function automatic void model_align(input logic [31:0] a, input logic [63:0] d,
                                      input logic [1:0] sz, input int lanes,
                                      output logic [31:0] line, output logic [63:0] data,
                                      output logic [7:0] be, output bit mis);
    int nb;
    int off;
    logic [63:0] mask;
    case (sz)
      2'b01:   nb = 1;
      2'b10:   nb = 2;
      2'b00:   nb = 4;
      default: nb = 8;
    endcase
    off  = int'(a % 32'(lanes));
    mis  = (nb > lanes) || ((off % nb) != 0);
    line = a - 32'(off);
    mask = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
    data = (d & mask) << (8 * off);
    be   = 8'((8'd1 << nb) - 8'd1) << off;
  endfunction

  logic [31:0] m_line;
  logic [63:0] m_data;
  logic [7:0]  m_be;
  bit          m_mis, m_acc, m_pop;
  ent_t        m_t;

  // Model update on each clock edge (cleared by reset at any time).
  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      q.delete();
      err_exp = 1'b0;
    end else begin
      model_align(st_addr, 64'(st_data), st_size, 4, m_line, m_data, m_be, m_mis);
      m_pop   = (q.size() != 0) && mem_ready;
      m_acc   = st_valid && (m_mis || q.size() < DEPTH);
      err_exp = st_valid && m_mis;
      if (m_acc && !m_mis && q.size() >= 2 && q[q.size()-1].a == m_line) begin
        m_t = q[q.size()-1];
        for (int b = 0; b < 8; b++) if (m_be[b]) m_t.d[8*b +: 8] = m_data[8*b +: 8];
        m_t.be = m_t.be | m_be;
        q[q.size()-1] = m_t;
        if (m_pop) void'(q.pop_front());
      end else begin
        if (m_pop) void'(q.pop_front());
        if (m_acc && !m_mis) begin
          m_t.a  = m_line;
          m_t.d  = m_data;
          m_t.be = m_be;
          q.push_back(m_t);
        end
      end
    end
  end

  logic [31:0] c_line;
  logic [63:0] c_data;
  logic [7:0]  c_be;
  bit          c_mis;

  // Every-cycle comparison of the DW=32 instance against the model.
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      model_align(st_addr, 64'(st_data), st_size, 4, c_line, c_data, c_be, c_mis);
      chk("mem_valid", 64'(mem_valid), 64'(q.size() != 0));
      chk("sb_empty",  64'(sb_empty),  64'(q.size() == 0));
      chk("mem_addr",  64'(mem_addr),  (q.size() != 0) ? 64'(q[0].a) : 64'd0);
      chk("mem_wdata", 64'(mem_wdata), (q.size() != 0) ? q[0].d : 64'd0);
      chk("mem_be",    64'(mem_be),    (q.size() != 0) ? 64'(q[0].be) : 64'd0);
      chk("st_err",    64'(st_err),    64'(err_exp));
      chk("st_ready",  64'(st_ready),  64'(c_mis || q.size() < DEPTH));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic put(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    st_valid = 1'b1; st_addr = a; st_data = d; st_size = sz;
    cyc();
    st_valid = 1'b0;
  endtask

  task automatic put64(input logic [31:0] a, input logic [63:0] d, input logic [1:0] sz);
    w_st_valid = 1'b1; w_st_addr = a; w_st_data = d; w_st_size = sz;
    cyc();
    w_st_valid = 1'b0;
  endtask

  localparam logic [31:0] TA [12] = '{32'h800, 32'h804, 32'h806, 32'h807, 32'h902, 32'h903,
                                       32'h900, 32'h901, 32'hA00, 32'hA01, 32'hA02, 32'hA03};
  localparam logic [31:0] TD [12] = '{32'h01020304, 32'h5566, 32'h7788, 32'h99, 32'h12345678, 32'hAA,
                                       32'hCAFEF00D, 32'h4455, 32'h01, 32'h02, 32'h03, 32'h04};
  localparam logic [1:0]  TS [12] = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b00, 2'b01,
                                       2'b11, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01};
  localparam logic [11:0] TR = 12'b1100_0011_0010;

  initial begin
    reset = 1'b1;
    st_valid = 1'b0; st_addr = '0; st_data = '0; st_size = '0; mem_ready = 1'b0;
    w_st_valid = 1'b0; w_st_addr = '0; w_st_data = '0; w_st_size = '0; w_mem_ready = 1'b0;
    #1;
    chk("rst_mem_valid", 64'(mem_valid), 64'd0);
    chk("rst_sb_empty",  64'(sb_empty),  64'd1);
    chk("rst_st_ready",  64'(st_ready),  64'd1);
    chk("rst_st_err",    64'(st_err),    64'd0);
    chk("rst_mem_be",    64'(mem_be),    64'd0);
    chk("rst64_empty",   64'(w_sb_empty), 64'd1);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;

    // Byte lane placement, first store after reset.
    put(32'h13, 32'hAB, SZ_BYTE);
    chk("byte_valid", 64'(mem_valid), 64'd1);
    chk("byte_addr",  64'(mem_addr),  64'h10);
    chk("byte_be",    64'(mem_be),    64'b1000);
    chk("byte_wdata", 64'(mem_wdata), 64'hAB000000);
    mem_ready = 1'b1; cyc(); mem_ready = 1'b0;
    chk("byte_drained", 64'(sb_empty), 64'd1);

    // Misaligned word: accepted, one-cycle error, nothing buffered.
    st_valid = 1'b1; st_addr = 32'h06; st_data = 32'hDEADBEEF; st_size = SZ_WORD;
    #1 chk("mis_ready", 64'(st_ready), 64'd1);
    cyc(); st_valid = 1'b0;
    chk("mis_err1",   64'(st_err),   64'd1);
    chk("mis_empty1", 64'(sb_empty), 64'd1);
    cyc();
    chk("mis_err2",   64'(st_err),   64'd0);
    chk("mis_empty2", 64'(sb_empty), 64'd1);

    // Merge into tail.
    put(32'h100, 32'h12345678, SZ_WORD);
    put(32'h200, 32'hBEEF, SZ_HALF);
    put(32'h203, 32'h77, SZ_BYTE);
    chk("model_merge_cnt", 64'(q.size()), 64'd2);
    chk("model_merge_be",  64'(q[1].be), 64'h0B);
    chk("model_merge_d",   q[1].d, 64'h7700BEEF);
    chk("merge_head_addr", 64'(mem_addr), 64'h100);
    mem_ready = 1'b1; cyc();
    chk("merge_tail_addr", 64'(mem_addr),  64'h200);
    chk("merge_tail_be",   64'(mem_be),    64'b1011);
    chk("merge_tail_data", 64'(mem_wdata), 64'h7700BEEF);
    cyc(); mem_ready = 1'b0;
    chk("merge_drained", 64'(sb_empty), 64'd1);

    // Head entry is never merged into.
    put(32'h40, 32'h11, SZ_BYTE);
    put(32'h41, 32'h22, SZ_BYTE);
    put(32'h42, 32'h33, SZ_BYTE);
    chk("model_head_cnt", 64'(q.size()), 64'd2);
    chk("head_be",   64'(mem_be),    64'b0001);
    chk("head_data", 64'(mem_wdata), 64'h11);
    mem_ready = 1'b1; cyc();
    chk("head2_be",   64'(mem_be),    64'b0110);
    chk("head2_data", 64'(mem_wdata), 64'h00332200);
    cyc(); mem_ready = 1'b0;

    // Full buffer: pop does not let a push through in the same cycle.
    for (int i = 0; i < 4; i++) put(32'h300 + 32'(4 * i), 32'hA0 + 32'(i), SZ_WORD);
    st_valid = 1'b1; st_addr = 32'h310; st_data = 32'hE5; st_size = SZ_WORD;
    #1 chk("full_ready", 64'(st_ready), 64'd0);
    mem_ready = 1'b1;
    #1 chk("full_ready_pop", 64'(st_ready), 64'd0);
    chk("full_head", 64'(mem_addr), 64'h300);
    cyc();
    chk("after_pop_head",  64'(mem_addr), 64'h304);
    chk("after_pop_ready", 64'(st_ready), 64'd1);
    cyc(); st_valid = 1'b0;
    chk("push_pop_head", 64'(mem_addr), 64'h308);
    cyc(); cyc();
    chk("late_push_addr", 64'(mem_addr),  64'h310);
    chk("late_push_data", 64'(mem_wdata), 64'hE5);
    cyc(); mem_ready = 1'b0;
    chk("full_drained", 64'(sb_empty), 64'd1);

    // Misaligned store while full is still accepted.
    for (int i = 0; i < 4; i++) put(32'h700 + 32'(16 * i), 32'h5 + 32'(i), SZ_WORD);
    st_valid = 1'b1; st_addr = 32'h701; st_data = 32'h1234; st_size = SZ_HALF;
    #1 chk("full_mis_ready", 64'(st_ready), 64'd1);
    cyc(); st_valid = 1'b0;
    chk("full_mis_err", 64'(st_err), 64'd1);
    chk("model_full_cnt", 64'(q.size()), 64'd4);
    mem_ready = 1'b1; repeat (4) cyc(); mem_ready = 1'b0;

    // Mixed traffic with concurrent push/pop and pointer wrap.
    for (int i = 0; i < 12; i++) begin
      mem_ready = TR[i];
      put(TA[i], TD[i], TS[i]);
    end
    mem_ready = 1'b1; repeat (6) cyc(); mem_ready = 1'b0;
    chk("mixed_drained", 64'(sb_empty), 64'd1);

    // Asynchronous reset with entries queued.
    put(32'h500, 32'h1, SZ_WORD);
    put(32'h504, 32'h2, SZ_WORD);
    put(32'h508, 32'h3, SZ_WORD);
    chk("pre_rst_valid", 64'(mem_valid), 64'd1);
    #5 reset = 1'b1;
    #1;
    chk("async_valid", 64'(mem_valid), 64'd0);
    chk("async_empty", 64'(sb_empty),  64'd1);
    chk("async_addr",  64'(mem_addr),  64'd0);
    chk("async_ready", 64'(st_ready),  64'd1);
    @(posedge clk); #2 reset = 1'b0;
    put(32'h600, 32'h5A5A5A5A, SZ_WORD);
    chk("post_rst_valid", 64'(mem_valid), 64'd1);
    chk("post_rst_addr",  64'(mem_addr),  64'h600);
    chk("post_rst_data",  64'(mem_wdata), 64'h5A5A5A5A);
    mem_ready = 1'b1; cyc(); mem_ready = 1'b0;

    // 64-bit data path.
    put64(32'h08, 64'h1122334455667788, SZ_DWORD);
    chk("dw_valid", 64'(w_mem_valid), 64'd1);
    chk("dw_be",    64'(w_mem_be),    64'hFF);
    chk("dw_addr",  64'(w_mem_addr),  64'h08);
    chk("dw_data",  w_mem_wdata,      64'h1122334455667788);
    w_mem_ready = 1'b1; cyc(); w_mem_ready = 1'b0;
    chk("dw_drained", 64'(w_sb_empty), 64'd1);
    put64(32'h0C, 64'hFFFF, SZ_DWORD);
    chk("dw_mis_err",   64'(w_st_err),   64'd1);
    chk("dw_mis_empty", 64'(w_sb_empty), 64'd1);
    chk("dw_ready",     64'(w_st_ready), 64'd1);
    put64(32'h0D, 64'h5C, SZ_BYTE);
    chk("dw_byte_addr", 64'(w_mem_addr), 64'h08);
    chk("dw_byte_be",   64'(w_mem_be),   64'h20);
    chk("dw_byte_data", w_mem_wdata,     64'h00005C0000000000);
    w_mem_ready = 1'b1; cyc(); w_mem_ready = 1'b0;
    cyc();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
